// File: rtl/button_press_emitter.sv
// Emits 0-3 emulated button presses (bounce, press, gap) on B when start is accepted.
// Outputs are flop-driven; start is ignored while busy and accepted again in FINISH.
module button_press_emitter #(
  parameter int PRESS_CYCLES  = 100,
  parameter int GAP_CYCLES    = 100,
  parameter int BOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] count,
  output logic       busy,
  output logic       done,
  output logic       B
);

  localparam int MAX_CYCLES = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOUNCE_END = CNT_W'(BOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       remaining, remaining_nxt;
  logic             b_nxt, busy_nxt, done_nxt;

  // State register; outputs are registered copies of their next-cycle values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      remaining <= 2'd0;
      B         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      remaining <= remaining_nxt;
      B         <= b_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    remaining_nxt = remaining;
    case (state)
      IDLE, FINISH: begin
        if (start) begin
          remaining_nxt = count;
          cnt_nxt       = '0;
          state_nxt     = (count == 2'd0) ? FINISH : PRESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      PRESS: begin
        if (cnt == PRESS_LAST) begin
          remaining_nxt = remaining - 2'd1;
          cnt_nxt       = '0;
          state_nxt     = GAP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (remaining == 2'd0) ? FINISH : PRESS;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so the flops present it in that cycle.
  always_comb begin
    b_nxt    = 1'b0;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      PRESS: begin
        busy_nxt = 1'b1;
        // Contact bounce: high on even indices within the leading bounce window.
        b_nxt    = (cnt_nxt >= BOUNCE_END) || !cnt_nxt[0];
      end
      GAP:    busy_nxt = 1'b1;
      FINISH: done_nxt = 1'b1;
      default: ;
    endcase
  end

endmodule
